// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch front end.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // FETCH: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {pc, inst} pairs between memory and decode.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_inst,
    output logic            full,
    output logic            empty,
    output logic [1:0]      count,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst
);

    logic [XLEN-1:0] pc_mem   [2];
    logic [XLEN-1:0] inst_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count_q;
    logic            do_push;
    logic            do_pop;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign count     = count_q;
    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            // Flush wins over a simultaneous push or pop.
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]   <= push_pc;
                inst_mem[wr_ptr] <= push_inst;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding memory read, two-entry buffer,
// redirect handling that flushes the buffer and discards in-flight responses.
module fetch_controller
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [1:0]  state
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic [1:0]      fifo_count;
    logic [2:0]      occupancy;
    logic            outstanding;
    logic            issued;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2:0]      unused_sigs;

    assign unused_sigs = {fifo_full, redirect_pc[1:0]};

    assign state       = state_q;
    assign outstanding = (state_q != FETCH);
    assign occupancy   = {1'b0, fifo_count} + {2'b00, outstanding};
    assign imem_addr   = fetch_pc_q;
    assign issued      = imem_req && imem_ready;
    assign inst_valid  = !fifo_empty;
    assign fifo_pop    = inst_valid && inst_ready;

    // Request is suppressed on redirect so a redirect never races an accepted request.
    assign imem_req = !rst && (state_q == FETCH) && !redirect_valid
                      && (occupancy < 3'(FIFO_DEPTH));

    always_comb begin
        state_d   = state_q;
        fifo_push = 1'b0;
        case (state_q)
            FETCH: begin
                if (issued) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d   = FETCH;
                    fifo_push = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issued) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (issued) req_pc_q <= fetch_pc_q;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .push_pc   (req_pc_q),
        .push_inst (imem_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_pc   (inst_pc),
        .head_inst (inst_out)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: table-driven streaming vectors plus
// hand-written redirect, wrap and reset sequences.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [1:0]  state;

    fetch_controller #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .state          (state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    typedef struct {
        bit          first;
        logic        rdy;
        logic        irdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        vecs [40];
    int          n_vecs = 0;
    int          checks = 0;
    int          errors = 0;
    logic        auto_mem = 1'b1;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit first, input logic rdy, input logic irdy, input logic e_req,
                           input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
        vecs[n_vecs] = '{first, rdy, irdy, e_req, e_addr, e_valid, e_pc};
        n_vecs++;
    endtask

    // One clock: scoreboard any pop, let the edge happen, then play the memory responder.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic [63:0] e;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        if (inst_valid === 1'b1)
            chk("dropped_data_visible", {31'b0, inst_out == 32'hDEADBEEF}, 32'd0);
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_pop: got pc %h inst %h expected no pop", inst_pc, inst_out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e[63:32]);
                chk("sb_inst", inst_out, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = acc;
            imem_rdata  = acc ? mem_word(a) : 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   imem_req,   32'd0);
        chk({tag, "_addr"},  imem_addr,  32'h0);
        chk({tag, "_valid"}, inst_valid, 32'd0);
        chk({tag, "_out"},   inst_out,   32'h0);
        chk({tag, "_pc"},    inst_pc,    32'h0);
        chk({tag, "_state"}, state,      S_FETCH);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b1;
        #1;
        chk_reset_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;

        // Streaming with rvalid one cycle after each accept
        add_vec(1, 1, 1, 1, 32'h0, 0, 32'h0);
        add_vec(0, 1, 1, 0, 32'h4, 0, 32'h0);
        add_vec(0, 1, 1, 1, 32'h4, 1, 32'h0);
        add_vec(0, 1, 1, 0, 32'h8, 0, 32'h0);
        add_vec(0, 1, 1, 1, 32'h8, 1, 32'h4);
        add_vec(0, 1, 1, 0, 32'hC, 0, 32'h0);
        add_vec(0, 1, 1, 1, 32'hC, 1, 32'h8);
        // Decoder stalled: buffer fills to two, then one release allows one request
        add_vec(1, 1, 0, 1, 32'h0, 0, 32'h0);
        add_vec(0, 1, 0, 0, 32'h4, 0, 32'h0);
        add_vec(0, 1, 0, 1, 32'h4, 1, 32'h0);
        add_vec(0, 1, 0, 0, 32'h8, 1, 32'h0);
        add_vec(0, 1, 0, 0, 32'h8, 1, 32'h0);
        add_vec(0, 1, 0, 0, 32'h8, 1, 32'h0);
        add_vec(0, 1, 0, 0, 32'h8, 1, 32'h0);
        add_vec(0, 1, 1, 0, 32'h8, 1, 32'h0);
        add_vec(0, 1, 0, 1, 32'h8, 1, 32'h4);
        add_vec(0, 1, 0, 0, 32'hC, 1, 32'h4);
        add_vec(0, 1, 0, 0, 32'hC, 1, 32'h4);
        add_vec(0, 1, 0, 0, 32'hC, 1, 32'h4);
        // Memory not ready for three cycles: request held at 0x8
        add_vec(1, 1, 1, 1, 32'h0, 0, 32'h0);
        add_vec(0, 1, 1, 0, 32'h4, 0, 32'h0);
        add_vec(0, 1, 1, 1, 32'h4, 1, 32'h0);
        add_vec(0, 1, 1, 0, 32'h8, 0, 32'h0);
        add_vec(0, 0, 1, 1, 32'h8, 1, 32'h4);
        add_vec(0, 0, 1, 1, 32'h8, 0, 32'h0);
        add_vec(0, 0, 1, 1, 32'h8, 0, 32'h0);
        add_vec(0, 1, 1, 1, 32'h8, 0, 32'h0);
        add_vec(0, 1, 1, 0, 32'hC, 0, 32'h0);
        add_vec(0, 1, 1, 1, 32'hC, 1, 32'h8);

        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back({32'h0, mem_word(32'h0)});
        exp_q.push_back({32'h4, mem_word(32'h4)});
        exp_q.push_back({32'h8, mem_word(32'h8)});
        exp_q.push_back({32'h0, mem_word(32'h0)});
        exp_q.push_back({32'h0, mem_word(32'h0)});
        exp_q.push_back({32'h4, mem_word(32'h4)});
        exp_q.push_back({32'h8, mem_word(32'h8)});

        @(negedge clk);
        auto_mem = 1'b1;
        for (int i = 0; i < n_vecs; i++) begin
            if (vecs[i].first) do_reset();
            imem_ready = vecs[i].rdy;
            inst_ready = vecs[i].irdy;
            #1;
            chk($sformatf("v%0d_req", i),   imem_req,   vecs[i].e_req);
            chk($sformatf("v%0d_addr", i),  imem_addr,  vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), inst_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i),   inst_pc,  vecs[i].e_pc);
                chk($sformatf("v%0d_inst", i), inst_out, mem_word(vecs[i].e_pc));
            end
            tick();
        end
        chk("table_sb_drain", exp_q.size(), 32'd0);

        // Redirect while waiting; stale response must be dropped
        do_reset();
        auto_mem = 1'b0;
        #1; chk("rd_c0_req", imem_req, 32'd1); chk("rd_c0_addr", imem_addr, 32'h0);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1; chk("rd_c1_state", state, S_WAIT); chk("rd_c1_req", imem_req, 32'd0);
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1; chk("rd_c2_state", state, S_DROP); chk("rd_c2_req", imem_req, 32'd0);
        chk("rd_c2_valid", inst_valid, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        #1; chk("rd_c3_state", state, S_FETCH); chk("rd_c3_req", imem_req, 32'd1);
        chk("rd_c3_addr", imem_addr, 32'h100); chk("rd_c3_valid", inst_valid, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        exp_q.push_back({32'h100, 32'h1111_1111});
        #1; chk("rd_c4_state", state, S_WAIT);
        tick();
        imem_rvalid = 1'b0;
        #1; chk("rd_c5_valid", inst_valid, 32'd1); chk("rd_c5_pc", inst_pc, 32'h100);
        chk("rd_c5_inst", inst_out, 32'h1111_1111); chk("rd_c5_addr", imem_addr, 32'h104);
        chk("rd_c5_req", imem_req, 32'd1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1; chk("rd_c6_state", state, S_WAIT); chk("rd_c6_req", imem_req, 32'd0);
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b0;
        #1; chk("rd_c7_state", state, S_FETCH); chk("rd_c7_req", imem_req, 32'd1);
        chk("rd_c7_addr", imem_addr, 32'h200); chk("rd_c7_valid", inst_valid, 32'd0);
        tick();
        chk("rd_sb_drain", exp_q.size(), 32'd0);

        // Redirect to the top word; next fetch wraps to zero
        do_reset();
        auto_mem = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1; chk("wr_c0_req", imem_req, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1; chk("wr_c1_req", imem_req, 32'd1); chk("wr_c1_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        #1; chk("wr_c2_state", state, S_WAIT);
        tick();
        #1; chk("wr_c3_req", imem_req, 32'd1); chk("wr_c3_addr", imem_addr, 32'h0);
        chk("wr_c3_valid", inst_valid, 32'd1); chk("wr_c3_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("wr_sb_drain", exp_q.size(), 32'd0);

        // Reset asserted while waiting with one buffered entry
        do_reset();
        auto_mem = 1'b0;
        inst_ready = 1'b0;
        #1; tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001;
        #1; chk("mr_c1_state", state, S_WAIT);
        tick();
        imem_rvalid = 1'b0;
        #1; chk("mr_c2_valid", inst_valid, 32'd1); chk("mr_c2_addr", imem_addr, 32'h4);
        chk("mr_c2_req", imem_req, 32'd1);
        tick();
        #1; chk("mr_c3_state", state, S_WAIT); chk("mr_c3_valid", inst_valid, 32'd1);
        rst = 1'b1;
        #1; chk_reset_outputs("mr_async");
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        #1; chk_reset_outputs("mr_stray");
        rst = 1'b0; imem_rvalid = 1'b0;
        #1; chk("mr_rel_req", imem_req, 32'd1); chk("mr_rel_addr", imem_addr, 32'h0);
        chk("mr_rel_valid", inst_valid, 32'd0);
        tick();
        #1; chk("mr_post_state", state, S_WAIT); chk("mr_post_valid", inst_valid, 32'd0);
        chk("mr_sb_drain", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
